// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage and the writeback stage that
// consumes its registered writeback bundle.
package mem_pkg;

  localparam int DATA_W           = 32;
  localparam int REG_ADDR_W       = 5;
  localparam int WAIT_MAX_DEFAULT = 16;

  // IDLE accepts a new instruction; ACCESS owns an outstanding data-memory request
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bundle between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;
  import mem_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage. Non-memory instructions pass straight through with
// one cycle of latency; aligned loads/stores latch their operands, stall the
// EX stage and hold a request on the data memory until it acknowledges or
// the wait counter expires. Misaligned accesses retire at once with an error.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_2_mem,
  input  logic [DATA_W-1:0]     alu_result_2_mem,
  input  logic [DATA_W-1:0]     addr_2_mem,
  input  logic [DATA_W-1:0]     st_data_2_mem,
  input  logic                  mem_read_2_mem,
  input  logic                  mem_write_2_mem,
  input  logic                  mem_to_reg_2_mem,
  input  logic [REG_ADDR_W-1:0] rd_add_value_2_mem,
  mem_stage_if.master           dmem,
  output logic                  stall_2_ex,
  output logic                  valid_2_wb,
  output logic                  reg_write_2_wb,
  output logic [REG_ADDR_W-1:0] rd_add_value_2_wb,
  output logic [DATA_W-1:0]     wb_data_2_wb,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  mem_state_e            state_q, state_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic                  store_q, store_d;
  logic                  to_reg_q, to_reg_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic                  valid_wb_q, valid_wb_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_wb_q, rd_wb_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  misalign_q, misalign_d;
  logic                  timeout_q, timeout_d;

  logic stall_raw;
  logic mem_op;
  logic aligned;

  assign mem_op  = mem_read_2_mem | mem_write_2_mem;
  assign aligned = (addr_2_mem[1:0] == 2'b00);

  // State, latched operands and the registered writeback bundle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      alu_q       <= '0;
      store_q     <= 1'b0;
      to_reg_q    <= 1'b0;
      rd_q        <= '0;
      wait_q      <= '0;
      valid_wb_q  <= 1'b0;
      reg_write_q <= 1'b0;
      rd_wb_q     <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      alu_q       <= alu_d;
      store_q     <= store_d;
      to_reg_q    <= to_reg_d;
      rd_q        <= rd_d;
      wait_q      <= wait_d;
      valid_wb_q  <= valid_wb_d;
      reg_write_q <= reg_write_d;
      rd_wb_q     <= rd_wb_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state, operand capture, retirement and stall decisions
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    alu_d       = alu_q;
    store_d     = store_q;
    to_reg_d    = to_reg_q;
    rd_d        = rd_q;
    wait_d      = wait_q;
    valid_wb_d  = 1'b0;
    reg_write_d = 1'b0;
    rd_wb_d     = rd_wb_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    stall_raw   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_2_mem) begin
          if (!mem_op) begin
            valid_wb_d  = 1'b1;
            reg_write_d = (rd_add_value_2_mem != '0);
            rd_wb_d     = rd_add_value_2_mem;
            wb_data_d   = alu_result_2_mem;
          end else if (!aligned) begin
            valid_wb_d  = 1'b1;
            rd_wb_d     = rd_add_value_2_mem;
            wb_data_d   = alu_result_2_mem;
            misalign_d  = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = ACCESS;
            addr_d    = addr_2_mem;
            wdata_d   = st_data_2_mem;
            alu_d     = alu_result_2_mem;
            store_d   = mem_write_2_mem;
            to_reg_d  = mem_to_reg_2_mem;
            rd_d      = rd_add_value_2_mem;
            wait_d    = '0;
          end
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d     = IDLE;
          wait_d      = '0;
          valid_wb_d  = 1'b1;
          reg_write_d = !store_q && (rd_q != '0);
          rd_wb_d     = rd_q;
          wb_data_d   = to_reg_q ? dmem.dmem_rdata : alu_q;
        end else if (wait_q == WAIT_LAST) begin
          state_d    = IDLE;
          wait_d     = '0;
          valid_wb_d = 1'b1;
          rd_wb_d    = rd_q;
          wb_data_d  = alu_q;
          timeout_d  = 1'b1;
        end else begin
          stall_raw = 1'b1;
          wait_d    = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_2_ex = stall_raw & ~reset;

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = (state_q == ACCESS) & store_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign valid_2_wb        = valid_wb_q;
  assign reg_write_2_wb    = reg_write_q;
  assign rd_add_value_2_wb = rd_wb_q;
  assign wb_data_2_wb      = wb_data_q;
  assign misalign_err      = misalign_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads, stores,
// misaligned access, wait timeout and reset during an outstanding access.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        validIn;
  logic [31:0] aluIn;
  logic [31:0] addrIn;
  logic [31:0] stDataIn;
  logic        memReadIn;
  logic        memWriteIn;
  logic        memToRegIn;
  logic [4:0]  rdIn;
  logic        stall;
  logic        validWb;
  logic        regWriteWb;
  logic [4:0]  rdWb;
  logic [31:0] wbData;
  logic        misalignErr;
  logic        timeoutErr;

  int testsRun;
  int testsFailed;

  mem_stage_if dmemIf ();

  mem_stage #(.WAIT_MAX(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_2_mem       (validIn),
    .alu_result_2_mem  (aluIn),
    .addr_2_mem        (addrIn),
    .st_data_2_mem     (stDataIn),
    .mem_read_2_mem    (memReadIn),
    .mem_write_2_mem   (memWriteIn),
    .mem_to_reg_2_mem  (memToRegIn),
    .rd_add_value_2_mem(rdIn),
    .dmem              (dmemIf),
    .stall_2_ex        (stall),
    .valid_2_wb        (validWb),
    .reg_write_2_wb    (regWriteWb),
    .rd_add_value_2_wb (rdWb),
    .wb_data_2_wb      (wbData),
    .misalign_err      (misalignErr),
    .timeout_err       (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one EX-stage instruction (or a bubble when v=0)
  task automatic applyStimulus(input logic v, input logic rdOp, input logic wrOp, input logic toReg,
                               input logic [31:0] alu, input logic [31:0] addr,
                               input logic [31:0] stData, input logic [4:0] rd);
    validIn    = v;
    memReadIn  = rdOp;
    memWriteIn = wrOp;
    memToRegIn = toReg;
    aluIn      = alu;
    addrIn     = addr;
    stDataIn   = stData;
    rdIn       = rd;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    dmemIf.dmem_ack   = 1'b0;
    dmemIf.dmem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);

    tick();
    tick();
    checkOutput("rst_valid_wb", {31'b0, validWb}, 32'd0);
    checkOutput("rst_req", {31'b0, dmemIf.dmem_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_errs", {30'b0, misalignErr, timeoutErr}, 32'd0);
    reset = 1'b0;

    // ALU op: retires next edge with data and reg_write
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_002A, 32'h0, 32'h0, 5'd5);
    #1;
    checkOutput("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    checkOutput("alu_valid", {31'b0, validWb}, 32'd1);
    checkOutput("alu_data", wbData, 32'h2A);
    checkOutput("alu_regwr", {31'b0, regWriteWb}, 32'd1);
    checkOutput("alu_rd", {27'b0, rdWb}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("bubble_valid", {31'b0, validWb}, 32'd0);

    // ALU op to r0 never writes the register file
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("r0_valid", {31'b0, validWb}, 32'd1);
    checkOutput("r0_regwr", {31'b0, regWriteWb}, 32'd0);

    // Load at 0x100: stall 3 cycles, ack on the third ACCESS cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 32'h100, 32'h0, 5'd7);
    #1;
    checkOutput("ld_stall0", {31'b0, stall}, 32'd1);
    checkOutput("ld_noreq0", {31'b0, dmemIf.dmem_req}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h99, 32'h999, 32'h77, 5'd9);
    #1;
    checkOutput("ld_req", {31'b0, dmemIf.dmem_req}, 32'd1);
    checkOutput("ld_we", {31'b0, dmemIf.dmem_we}, 32'd0);
    checkOutput("ld_addr", dmemIf.dmem_addr, 32'h100);
    checkOutput("ld_stall1", {31'b0, stall}, 32'd1);
    checkOutput("ld_nowb", {31'b0, validWb}, 32'd0);
    tick();
    checkOutput("ld_stall2", {31'b0, stall}, 32'd1);
    tick();
    dmemIf.dmem_ack   = 1'b1;
    dmemIf.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("ld_stall_ack", {31'b0, stall}, 32'd0);
    tick();
    dmemIf.dmem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("ld_valid", {31'b0, validWb}, 32'd1);
    checkOutput("ld_data", wbData, 32'hDEAD_BEEF);
    checkOutput("ld_rd", {27'b0, rdWb}, 32'd7);
    checkOutput("ld_regwr", {31'b0, regWriteWb}, 32'd1);
    checkOutput("ld_req_done", {31'b0, dmemIf.dmem_req}, 32'd0);

    // Store at 0x104: write strobe and data until ack, no register write
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h55, 5'd9);
    tick();
    #1;
    checkOutput("st_we", {31'b0, dmemIf.dmem_we}, 32'd1);
    checkOutput("st_wdata", dmemIf.dmem_wdata, 32'h55);
    checkOutput("st_addr", dmemIf.dmem_addr, 32'h104);
    dmemIf.dmem_ack = 1'b1;
    tick();
    dmemIf.dmem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("st_valid", {31'b0, validWb}, 32'd1);
    checkOutput("st_regwr", {31'b0, regWriteWb}, 32'd0);

    // Read and write together behave as a store
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h108, 32'hA5, 5'd6);
    tick();
    checkOutput("rw_we", {31'b0, dmemIf.dmem_we}, 32'd1);
    dmemIf.dmem_ack = 1'b1;
    tick();
    dmemIf.dmem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("rw_regwr", {31'b0, regWriteWb}, 32'd0);

    // Load without mem_to_reg writes back the latched ALU result
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hABCD, 32'h10C, 32'h0, 5'd8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmemIf.dmem_ack   = 1'b1;
    dmemIf.dmem_rdata = 32'h1111_2222;
    tick();
    dmemIf.dmem_ack = 1'b0;
    checkOutput("ldalu_data", wbData, 32'hABCD);
    checkOutput("ldalu_regwr", {31'b0, regWriteWb}, 32'd1);

    // Misaligned load: no request, no stall, error pulse
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h102, 32'h0, 5'd3);
    #1;
    checkOutput("mis_stall", {31'b0, stall}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("mis_req", {31'b0, dmemIf.dmem_req}, 32'd0);
    checkOutput("mis_err", {31'b0, misalignErr}, 32'd1);
    checkOutput("mis_valid", {31'b0, validWb}, 32'd1);
    checkOutput("mis_regwr", {31'b0, regWriteWb}, 32'd0);
    tick();
    checkOutput("mis_err_end", {31'b0, misalignErr}, 32'd0);

    // Ack while idle is ignored
    dmemIf.dmem_ack = 1'b1;
    tick();
    dmemIf.dmem_ack = 1'b0;
    checkOutput("idle_ack_valid", {31'b0, validWb}, 32'd0);
    checkOutput("idle_ack_req", {31'b0, dmemIf.dmem_req}, 32'd0);

    // Timeout: 16 ACCESS cycles without ack abort the access
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 5'd4);
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 0)  checkOutput("to_req", {31'b0, dmemIf.dmem_req}, 32'd1);
      if (i == 14) checkOutput("to_stall14", {31'b0, stall}, 32'd1);
      if (i == 15) checkOutput("to_stall15", {31'b0, stall}, 32'd0);
      if (i == 15) checkOutput("to_req15", {31'b0, dmemIf.dmem_req}, 32'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("to_err", {31'b0, timeoutErr}, 32'd1);
    checkOutput("to_valid", {31'b0, validWb}, 32'd1);
    checkOutput("to_regwr", {31'b0, regWriteWb}, 32'd0);
    checkOutput("to_idle_req", {31'b0, dmemIf.dmem_req}, 32'd0);
    tick();
    checkOutput("to_err_end", {31'b0, timeoutErr}, 32'd0);

    // Reset during ACCESS drops the request at once, nothing retires
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 5'd2);
    tick();
    checkOutput("rstacc_req", {31'b0, dmemIf.dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstacc_req_drop", {31'b0, dmemIf.dmem_req}, 32'd0);
    checkOutput("rstacc_stall", {31'b0, stall}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstacc_novalid", {31'b0, validWb}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
